// File: rtl/branch_resolver_pkg.sv
// Shared types for the EX-stage branch resolver and its feedback FIFO.
package branch_resolver_pkg;

    localparam int FB_ADDR_W = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    // Encodings 6 and 7 are unused and resolve as not taken.
    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        BLEZ = 3'd2,
        BGTZ = 3'd3,
        BLTZ = 3'd4,
        BGEZ = 3'd5
    } branch_cond_t;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } resolver_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] pc;
        BranchOutcome         prediction;
        BranchOutcome         outcome;
    } fb_record_t;

endpackage

// File: rtl/branch_resolver_fb_fifo.sv
// Synchronous FIFO of branch feedback records; DEPTH must be a power of two.
module branch_fb_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  fb_record_t               din,
    output fb_record_t               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    fb_record_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: condition evaluation, mispredict redirect, wrong-path squash
// and predictor feedback queue. Optional counters under BRANCH_RESOLVER_STATS_EN.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_WIDTH    = FB_ADDR_W,
    parameter int DATA_WIDTH    = 32,
    parameter int FB_DEPTH      = 4,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  branch_cond_t          i_cond,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    input  BranchOutcome          i_prediction,
    input  logic [ADDR_WIDTH-1:0] i_recovery_pc,
    output logic                  o_stall,
    output logic                  o_redirect_valid,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                  o_fb_valid,
    input  logic                  i_fb_ready,
    output logic [ADDR_WIDTH-1:0] o_fb_pc,
    output logic                  o_fb_prediction,
    output logic                  o_fb_outcome
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0]           o_stat_branches,
    output logic [31:0]           o_stat_mispredicts
`endif
);
    localparam int CW  = $clog2(FB_DEPTH) + 1;
    localparam int SCW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
    localparam logic [CW-1:0]  STALL_CNT   = CW'(FB_DEPTH);
    localparam logic [SCW-1:0] SQUASH_LOAD = SCW'(SQUASH_CYCLES - 1);

    resolver_state_t state;
    logic [SCW-1:0]  squash_cnt;
    BranchOutcome    outcome;
    logic            a_zero;
    logic            a_neg;
    logic            accept;
    logic            mispredict;
    logic            fb_full;
    logic            fb_empty;
    logic [CW-1:0]   fb_count;
    fb_record_t      fb_in;
    fb_record_t      fb_out;

    assign a_zero = (i_op_a == '0);
    assign a_neg  = i_op_a[DATA_WIDTH-1];

    // Zero-compare branches only need the sign bit and a zero detect.
    always_comb begin
        outcome = NOT_TAKEN;
        case (i_cond)
            BEQ:     outcome = BranchOutcome'(i_op_a == i_op_b);
            BNE:     outcome = BranchOutcome'(i_op_a != i_op_b);
            BLEZ:    outcome = BranchOutcome'(a_neg | a_zero);
            BGTZ:    outcome = BranchOutcome'(~a_neg & ~a_zero);
            BLTZ:    outcome = BranchOutcome'(a_neg);
            BGEZ:    outcome = BranchOutcome'(~a_neg);
            default: outcome = NOT_TAKEN;
        endcase
    end

    assign accept     = i_valid & ~fb_full & (state == RUN);
    assign mispredict = (outcome != i_prediction);

    assign fb_in.pc         = i_pc;
    assign fb_in.prediction = i_prediction;
    assign fb_in.outcome    = outcome;

    branch_fb_fifo #(.DEPTH(FB_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (i_fb_ready),
        .din   (fb_in),
        .dout  (fb_out),
        .full  (fb_full),
        .empty (fb_empty),
        .count (fb_count)
    );

    assign o_stall         = (fb_count == STALL_CNT);
    assign o_fb_valid      = ~fb_empty;
    assign o_fb_pc         = fb_out.pc;
    assign o_fb_prediction = fb_out.prediction;
    assign o_fb_outcome    = fb_out.outcome;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= RUN;
            squash_cnt       <= '0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
        end else begin
            o_redirect_valid <= accept & mispredict;
            if (accept & mispredict) o_redirect_pc <= i_recovery_pc;
            // accept already implies RUN, so SQUASH never sees a new redirect.
            case (state)
                RUN: begin
                    if (accept & mispredict) begin
                        state      <= SQUASH;
                        squash_cnt <= SQUASH_LOAD;
                    end
                end
                SQUASH: begin
                    if (squash_cnt == '0) state <= RUN;
                    else                  squash_cnt <= squash_cnt - 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (accept) begin
            if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
            if (mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

    assign o_stat_branches    = stat_branches;
    assign o_stat_mispredicts = stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a queue-based reference model checked every cycle.
module tb_branch_resolver;
    import branch_resolver_pkg::*;

    localparam int DEPTH = 4;
    localparam int SQ    = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic [31:0]  i_pc;
    branch_cond_t i_cond;
    logic [31:0]  i_op_a;
    logic [31:0]  i_op_b;
    BranchOutcome i_prediction;
    logic [31:0]  i_recovery_pc;
    logic         o_stall;
    logic         o_redirect_valid;
    logic [31:0]  o_redirect_pc;
    logic         o_fb_valid;
    logic         i_fb_ready;
    logic [31:0]  o_fb_pc;
    logic         o_fb_prediction;
    logic         o_fb_outcome;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0]  o_stat_branches;
    logic [31:0]  o_stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolver #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FB_DEPTH(DEPTH), .SQUASH_CYCLES(SQ)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_valid          (i_valid),
        .i_pc             (i_pc),
        .i_cond           (i_cond),
        .i_op_a           (i_op_a),
        .i_op_b           (i_op_b),
        .i_prediction     (i_prediction),
        .i_recovery_pc    (i_recovery_pc),
        .o_stall          (o_stall),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_fb_valid       (o_fb_valid),
        .i_fb_ready       (i_fb_ready),
        .o_fb_pc          (o_fb_pc),
        .o_fb_prediction  (o_fb_prediction),
        .o_fb_outcome     (o_fb_outcome)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .o_stat_branches    (o_stat_branches),
        .o_stat_mispredicts (o_stat_mispredicts)
`endif
    );

    // Reference model: a queue of records, a squash countdown and the last redirect.
    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic        outc;
    } rec_t;

    rec_t        mq[$];
    int          m_squash;
    logic        m_redir;
    logic [31:0] m_redir_pc;
    int          m_br;
    int          m_mis;
    int          vectors = 0;
    int          errors  = 0;
    bit          started = 1'b0;

    function automatic logic ref_taken(input branch_cond_t c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            BEQ:     return a == b;
            BNE:     return a != b;
            BLEZ:    return $signed(a) <= 0;
            BGTZ:    return $signed(a) > 0;
            BLTZ:    return $signed(a) < 0;
            BGEZ:    return $signed(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        bit full, take, tk, mis;
        if (!rst_n) begin
            mq.delete();
            m_squash   = 0;
            m_redir    = 1'b0;
            m_redir_pc = '0;
            m_br       = 0;
            m_mis      = 0;
            return;
        end
        full = (mq.size() == DEPTH);
        take = i_valid && !full && (m_squash == 0);
        if (m_squash > 0) m_squash--;
        tk  = ref_taken(i_cond, i_op_a, i_op_b);
        mis = take && (tk != i_prediction);
        if (i_fb_ready && mq.size() > 0) void'(mq.pop_front());
        if (take) mq.push_back('{i_pc, i_prediction, tk});
        m_redir = mis;
        if (mis) begin
            m_redir_pc = i_recovery_pc;
            m_squash   = SQ;
        end
        if (take) m_br++;
        if (mis)  m_mis++;
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("m_stall", o_stall, mq.size() == DEPTH);
        chk("m_fb_valid", o_fb_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("m_fb_pc", o_fb_pc, mq[0].pc);
            chk("m_fb_pred", o_fb_prediction, mq[0].pred);
            chk("m_fb_outcome", o_fb_outcome, mq[0].outc);
        end
        chk("m_redirect_valid", o_redirect_valid, m_redir);
        chk("m_redirect_pc", o_redirect_pc, m_redir_pc);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("m_stat_branches", o_stat_branches, m_br);
        chk("m_stat_mispredicts", o_stat_mispredicts, m_mis);
`endif
    endtask

    always @(negedge clk) if (started) compare_all();

    // Drives one EX-stage slot; returns at the middle of the following cycle.
    task automatic br(input logic v, input logic [31:0] pc, input branch_cond_t c,
                      input logic [31:0] a, input logic [31:0] b,
                      input BranchOutcome p, input logic [31:0] rec);
        i_valid       = v;
        i_pc          = pc;
        i_cond        = c;
        i_op_a        = a;
        i_op_b        = b;
        i_prediction  = p;
        i_recovery_pc = rec;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        i_valid       = 1'b0;
        i_pc          = '0;
        i_cond        = BEQ;
        i_op_a        = '0;
        i_op_b        = '0;
        i_prediction  = NOT_TAKEN;
        i_recovery_pc = '0;
        i_fb_ready    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        started = 1'b1;
        chk("rst_fb_valid", o_fb_valid, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_redirect_valid", o_redirect_valid, 0);
        chk("rst_redirect_pc", o_redirect_pc, 0);

        // 1: correctly predicted BEQ
        br(1, 32'h100, BEQ, 5, 5, TAKEN, 32'h104);
        chk("t1_fb_valid", o_fb_valid, 1);
        chk("t1_fb_pc", o_fb_pc, 32'h100);
        chk("t1_fb_outcome", o_fb_outcome, 1);
        chk("t1_fb_pred", o_fb_prediction, 1);
        chk("t1_no_redirect", o_redirect_valid, 0);
        idle(2);

        // 2: BNE mispredict, then two wrong-path slots
        br(1, 32'h200, BNE, 3, 3, TAKEN, 32'h0040_0108);
        chk("t2_redirect_valid", o_redirect_valid, 1);
        chk("t2_redirect_pc", o_redirect_pc, 32'h0040_0108);
        chk("t2_fb_outcome", o_fb_outcome, 0);
        br(1, 32'h204, BEQ, 7, 7, TAKEN, 0);
        chk("t2_pulse_once", o_redirect_valid, 0);
        chk("t2_squash1", o_fb_valid, 0);
        br(1, 32'h208, BEQ, 7, 7, TAKEN, 0);
        chk("t2_squash2", o_fb_valid, 0);
        br(1, 32'h20C, BEQ, 7, 7, TAKEN, 0);
        chk("t2_third_valid", o_fb_valid, 1);
        chk("t2_third_pc", o_fb_pc, 32'h20C);
        idle(2);

        // 3: BLTZ on the most negative value
        br(1, 32'h300, BLTZ, 32'h8000_0000, 0, NOT_TAKEN, 32'h304);
        chk("t3_redirect_valid", o_redirect_valid, 1);
        chk("t3_redirect_pc", o_redirect_pc, 32'h304);
        chk("t3_fb_outcome", o_fb_outcome, 1);
        idle(3);

        // remaining conditions, all correctly predicted
        br(1, 32'h310, BGTZ, 32'h7fff_ffff, 0, TAKEN, 0);
        br(1, 32'h314, BGEZ, 0, 0, TAKEN, 0);
        br(1, 32'h318, BLEZ, 32'hffff_ffff, 0, TAKEN, 0);
        br(1, 32'h31C, branch_cond_t'(3'd6), 4, 4, NOT_TAKEN, 0);
        chk("cond_unknown_outcome", o_fb_outcome, 0);
        chk("cond_unknown_pc", o_fb_pc, 32'h31C);
        br(1, 32'h320, BGTZ, 0, 0, NOT_TAKEN, 0);
        br(1, 32'h324, BLEZ, 1, 0, NOT_TAKEN, 0);
        chk("cond_blez_pos", o_fb_outcome, 0);
        idle(2);

        // 4: backpressure fills the FIFO
        i_fb_ready = 1'b0;
        for (int k = 0; k < 4; k++) br(1, 32'h400 + 4*k, BEQ, 1, 1, TAKEN, 0);
        chk("t4_stall_full", o_stall, 1);
        br(1, 32'h410, BEQ, 1, 1, TAKEN, 0);
        chk("t4_stall_held", o_stall, 1);
        chk("t4_head", o_fb_pc, 32'h400);
        i_fb_ready = 1'b1;
        br(1, 32'h410, BEQ, 1, 1, TAKEN, 0);
        chk("t4_stall_released", o_stall, 0);
        chk("t4_head_after_pop", o_fb_pc, 32'h404);
        i_fb_ready = 1'b0;
        br(1, 32'h410, BEQ, 1, 1, TAKEN, 0);
        chk("t4_fifth_accepted", o_stall, 1);
        i_valid    = 1'b0;
        i_fb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_order", o_fb_pc, 32'h404 + 4*k);
            @(negedge clk);
        end
        chk("t4_drained", o_fb_valid, 0);

        // 5: reset while full with a redirect in flight
        i_fb_ready = 1'b0;
        for (int k = 0; k < 3; k++) br(1, 32'h500 + 4*k, BEQ, 1, 1, TAKEN, 0);
        br(1, 32'h50C, BEQ, 1, 2, TAKEN, 32'h5F0);
        chk("t5_full", o_stall, 1);
        chk("t5_redirect", o_redirect_valid, 1);
        i_valid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_fb_valid", o_fb_valid, 0);
        chk("t5_stall", o_stall, 0);
        chk("t5_redirect_valid", o_redirect_valid, 0);
        i_fb_ready = 1'b1;
        br(1, 32'h600, BEQ, 9, 9, TAKEN, 0);
        chk("t5_run_after_reset", o_fb_valid, 1);
        chk("t5_run_pc", o_fb_pc, 32'h600);
        idle(2);

`ifdef BRANCH_RESOLVER_STATS_EN
        // 6: ten branches, three mispredicted
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bit mis;
            mis = (k == 0) || (k == 3) || (k == 6);
            br(1, 32'h700 + 4*k, BEQ, 1, 1, mis ? NOT_TAKEN : TAKEN, 32'h800);
            if (mis) idle(2);
        end
        idle(1);
        chk("t6_branches", o_stat_branches, 10);
        chk("t6_mispredicts", o_stat_mispredicts, 3);
`endif

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
